// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : In-order write buffer between the MEM stage and a
//                single-port data memory. Stores are accepted in one cycle,
//                drained FIFO to memory whenever no load needs the port, and
//                forwarded to loads so a load always sees the newest value
//                for its word address. This block owns the memory port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   clock, rising-edge
//    reset      in   1   asynchronous, active-high; clears pointers/count
//    st_valid   in   1   store issued this cycle
//    st_addr    in   32  store byte address (word store, [1:0] ignored)
//    st_data    in   32  store data
//    st_ready   out  1   buffer can accept a store (not full)
//    ld_valid   in   1   load issued this cycle
//    ld_addr    in   32  load byte address ([1:0] ignored for matching)
//    ld_data    out  32  load result, combinational
//    empty      out  1   no stores pending
//    mem_rd     out  1   data memory read enable
//    mem_wr     out  1   data memory write enable
//    mem_addr   out  32  data memory address
//    mem_wdata  out  32  data memory write data
//    mem_rdata  in   32  data memory combinational read data
// ============================================================================
module store_buffer #(
  parameter int DEPTH     = 4,
  parameter int DEPTH_BIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic        empty,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [DEPTH_BIT:0] C_DEPTH = (DEPTH_BIT+1)'(DEPTH);

  // Entry storage; contents need no reset because validity is defined
  // purely by rp/cnt.
  logic [29:0]          r_ent_addr [DEPTH];
  logic [31:0]          r_ent_data [DEPTH];
  logic [DEPTH_BIT-1:0] r_wp;
  logic [DEPTH_BIT-1:0] r_rp;
  logic [DEPTH_BIT:0]   r_cnt;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_drain;
  logic                 w_match;
  logic                 w_hit;
  logic                 w_miss;
  logic [31:0]          w_fwd_data;
  logic [DEPTH_BIT-1:0] w_idx;

  // Store address byte offset is irrelevant for word stores.
  logic w_unused;
  assign w_unused = &{1'b0, st_addr[1:0]};

  assign w_full   = (r_cnt == C_DEPTH);
  assign w_empty  = (r_cnt == '0);
  assign st_ready = !w_full;
  assign empty    = w_empty;

  assign w_push   = st_valid && !w_full;

  // Walk entries from oldest (rp) to youngest; a later match overwrites an
  // earlier one, so the youngest matching entry wins. Only registered
  // entries are searched, so a same-cycle push is not visible.
  always_comb begin
    w_match    = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rp + k[DEPTH_BIT-1:0];
      if (((DEPTH_BIT+1)'(k) < r_cnt) && (r_ent_addr[w_idx] == ld_addr[31:2])) begin
        w_match    = 1'b1;
        w_fwd_data = r_ent_data[w_idx];
      end
    end
  end

  assign w_hit   = ld_valid && w_match;
  assign w_miss  = ld_valid && !w_match;
  // The port is free for a drain whenever no load needs memory.
  assign w_drain = !w_empty && !w_miss;

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_data   = '0;
    if (w_miss) begin
      mem_rd   = 1'b1;
      mem_addr = ld_addr;
      ld_data  = mem_rdata;
    end else begin
      if (w_hit) begin
        ld_data = w_fwd_data;
      end
      if (w_drain) begin
        mem_wr    = 1'b1;
        mem_addr  = {r_ent_addr[r_rp], 2'b00};
        mem_wdata = r_ent_data[r_rp];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_drain) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_drain})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ent_addr[r_wp] <= st_addr[31:2];
      r_ent_data[r_wp] <= st_data;
    end
  end

endmodule
`default_nettype wire
